// File: rtl/tb_pzcorebus_master_seq_bfm_if.sv
// Corebus type package and the pzcorebus_if bundle used by the sequencing master.
// A zero-valued configuration field selects the package default width for that field.
package pzcorebus_bfm_pkg;
  typedef struct packed {
    logic [7:0] id_width;
    logic [7:0] address_width;
    logic [7:0] data_width;
    logic [7:0] length_width;
  } pzcorebus_config;

  typedef enum logic [2:0] {
    PZCOREBUS_NULL_COMMAND     = 3'd0,
    PZCOREBUS_READ             = 3'd1,
    PZCOREBUS_WRITE            = 3'd2,
    PZCOREBUS_WRITE_NON_POSTED = 3'd3,
    PZCOREBUS_ATOMIC           = 3'd4
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE      = 2'd0,
    PZCOREBUS_RESPONSE           = 2'd1,
    PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
  } pzcorebus_response_type;

  function automatic int cfg_id_width(pzcorebus_config c);
    return (c.id_width == '0) ? 8 : int'(c.id_width);
  endfunction

  function automatic int cfg_address_width(pzcorebus_config c);
    return (c.address_width == '0) ? 32 : int'(c.address_width);
  endfunction

  function automatic int cfg_data_width(pzcorebus_config c);
    return (c.data_width == '0) ? 32 : int'(c.data_width);
  endfunction

  function automatic int cfg_length_width(pzcorebus_config c);
    return (c.length_width == '0) ? 8 : int'(c.length_width);
  endfunction
endpackage

interface pzcorebus_if #(
  parameter pzcorebus_bfm_pkg::pzcorebus_config BUS_CONFIG = '0
) ();
  localparam int ID_W   = pzcorebus_bfm_pkg::cfg_id_width(BUS_CONFIG);
  localparam int ADDR_W = pzcorebus_bfm_pkg::cfg_address_width(BUS_CONFIG);
  localparam int DATA_W = pzcorebus_bfm_pkg::cfg_data_width(BUS_CONFIG);
  localparam int LEN_W  = pzcorebus_bfm_pkg::cfg_length_width(BUS_CONFIG);

  logic                                     mcmd_valid;
  logic                                     scmd_accept;
  pzcorebus_bfm_pkg::pzcorebus_command_type mcmd;
  logic [ID_W-1:0]                          mid;
  logic [ADDR_W-1:0]                        maddr;
  logic [LEN_W-1:0]                         mlength;
  logic                                     mdata_valid;
  logic                                     sdata_accept;
  logic [DATA_W-1:0]                        mdata;
  logic [DATA_W/8-1:0]                      mdata_byteen;
  logic                                     mdata_last;
  logic                                     sresp_valid;
  logic                                     mresp_accept;
  pzcorebus_bfm_pkg::pzcorebus_response_type sresp;
  logic [ID_W-1:0]                          sid;
  logic                                     serror;
  logic [DATA_W-1:0]                        sdata;
  logic                                     sresp_last;

  modport master (
    output mcmd_valid, mcmd, mid, maddr, mlength,
    output mdata_valid, mdata, mdata_byteen, mdata_last,
    output mresp_accept,
    input  scmd_accept, sdata_accept,
    input  sresp_valid, sresp, sid, serror, sdata, sresp_last
  );

  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mlength,
    input  mdata_valid, mdata, mdata_byteen, mdata_last,
    input  mresp_accept,
    output scmd_accept, sdata_accept,
    output sresp_valid, sresp, sid, serror, sdata, sresp_last
  );
endinterface

// File: rtl/tb_pzcorebus_master_seq_bfm.sv
// Sequencing corebus master: issues latched requests as command + data beats and
// checks returning responses against a per-tag table of outstanding requests.
//
// state | meaning
// IDLE  | waiting for a request; o_req_ready subject to the non-posted limit
// CMD   | mcmd_valid held with latched fields until scmd_accept
// DATA  | write beats (maddr + k) driven, advancing on sdata_accept
module tb_pzcorebus_master_seq_bfm
  import pzcorebus_bfm_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = '0,
  parameter int MAX_NON_POSTED_REQUESTS = 16,
  parameter int MAX_BEATS = 8,
  localparam int ID_W   = cfg_id_width(BUS_CONFIG),
  localparam int ADDR_W = cfg_address_width(BUS_CONFIG),
  localparam int DATA_W = cfg_data_width(BUS_CONFIG),
  localparam int LEN_W  = cfg_length_width(BUS_CONFIG),
  localparam int BEAT_W = $clog2(MAX_BEATS + 1),
  localparam int OUT_W  = $clog2(MAX_NON_POSTED_REQUESTS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  pzcorebus_command_type i_req_command,
  input  logic [ADDR_W-1:0]     i_req_address,
  input  logic [BEAT_W-1:0]     i_req_beats,
  pzcorebus_if.master           master_if,
  output logic [OUT_W-1:0]      o_outstanding,
  output logic [15:0]           o_error_count,
  output logic                  o_busy
);
  localparam int NP    = MAX_NON_POSTED_REQUESTS;
  localparam int TAG_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int REP   = (DATA_W + ADDR_W - 1) / ADDR_W;
  localparam logic [OUT_W-1:0]  NP_OUT    = OUT_W'(NP);
  localparam logic [ID_W:0]     NP_ID     = (ID_W + 1)'(NP);
  localparam logic [BEAT_W-1:0] MAX_BEATS_B = BEAT_W'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state_q, state_d;
  pzcorebus_command_type cmd_q, cmd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BEAT_W-1:0]     beats_q, beats_d, beat_q, beat_d, resp_idx_q, resp_idx_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [15:0]           err_q, err_d;
  pzcorebus_command_type tbl_cmd_q [NP];
  pzcorebus_command_type tbl_cmd_d [NP];
  logic [ADDR_W-1:0]     tbl_addr_q [NP];
  logic [ADDR_W-1:0]     tbl_addr_d [NP];
  logic [NP-1:0]         tbl_vld_q, tbl_vld_d;

  logic             req_fire, req_legal, np_fire, data_last, drop_err;
  logic             resp_fire, sid_hit, exp_rd, type_bad, data_bad, resp_err;
  logic [TAG_W-1:0] sid_idx;
  logic [16:0]      err_sum;

  function automatic logic [DATA_W-1:0] rep(input logic [ADDR_W-1:0] v);
    logic [REP*ADDR_W-1:0] wide;
    wide = {REP{v}};
    return wide[DATA_W-1:0];
  endfunction

  assign req_legal = (i_req_command inside {PZCOREBUS_READ, PZCOREBUS_WRITE,
                                            PZCOREBUS_WRITE_NON_POSTED})
                     && (i_req_beats != '0) && (i_req_beats <= MAX_BEATS_B);
  assign o_req_ready = i_rst_n && (state_q == IDLE)
                       && ((outstanding_q < NP_OUT) || (i_req_command == PZCOREBUS_WRITE));
  assign req_fire  = i_req_valid && o_req_ready;
  assign np_fire   = (state_q == CMD) && master_if.scmd_accept && (cmd_q != PZCOREBUS_WRITE);
  assign data_last = (beat_q == beats_q - BEAT_W'(1));

  assign master_if.mcmd_valid   = (state_q == CMD);
  assign master_if.mcmd         = cmd_q;
  assign master_if.maddr        = addr_q;
  assign master_if.mid          = (cmd_q == PZCOREBUS_WRITE) ? '0 : ID_W'(tag_q);
  assign master_if.mlength      = LEN_W'(beats_q - BEAT_W'(1));
  assign master_if.mdata_valid  = (state_q == DATA);
  assign master_if.mdata        = rep(addr_q + ADDR_W'(beat_q));
  assign master_if.mdata_byteen = '1;
  assign master_if.mdata_last   = data_last;
  assign master_if.mresp_accept = i_rst_n;

  assign o_outstanding = outstanding_q;
  assign o_error_count = err_q;
  assign o_busy        = (state_q != IDLE) || (outstanding_q != '0);

  // Response checking runs independently of the issue FSM.
  assign resp_fire = i_rst_n && master_if.sresp_valid;
  assign sid_idx   = TAG_W'(master_if.sid);
  assign sid_hit   = ({1'b0, master_if.sid} < NP_ID) && tbl_vld_q[sid_idx];
  assign exp_rd    = (tbl_cmd_q[sid_idx] == PZCOREBUS_READ);
  assign type_bad  = exp_rd ? (master_if.sresp != PZCOREBUS_RESPONSE_WITH_DATA)
                            : (master_if.sresp != PZCOREBUS_RESPONSE);
  assign data_bad  = exp_rd
                     && (master_if.sdata != rep(tbl_addr_q[sid_idx] + ADDR_W'(resp_idx_q)));
  assign resp_err  = resp_fire && (master_if.serror || !sid_hit || type_bad || data_bad);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    beat_d   = beat_q;
    tag_d    = tag_q;
    drop_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_legal) begin
            cmd_d   = i_req_command;
            addr_d  = i_req_address;
            beats_d = i_req_beats;
            beat_d  = '0;
            state_d = CMD;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      CMD: begin
        if (master_if.scmd_accept) begin
          if (cmd_q != PZCOREBUS_WRITE) begin
            tag_d = (tag_q == TAG_W'(NP - 1)) ? '0 : tag_q + TAG_W'(1);
          end
          state_d = (cmd_q == PZCOREBUS_READ) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (master_if.sdata_accept) begin
          if (data_last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(np_fire)
                    - OUT_W'(resp_fire && master_if.sresp_last && sid_hit);
    resp_idx_d = resp_idx_q;
    if (resp_fire) begin
      resp_idx_d = master_if.sresp_last ? '0 : resp_idx_q + BEAT_W'(1);
    end
    err_sum = {1'b0, err_q} + 17'(resp_err) + 17'(drop_err);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    tbl_cmd_d  = tbl_cmd_q;
    tbl_addr_d = tbl_addr_q;
    tbl_vld_d  = tbl_vld_q;
    if (resp_fire && master_if.sresp_last && sid_hit) begin
      tbl_vld_d[sid_idx] = 1'b0;
    end
    if (np_fire) begin
      tbl_vld_d[tag_q]  = 1'b1;
      tbl_cmd_d[tag_q]  = cmd_q;
      tbl_addr_d[tag_q] = addr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= PZCOREBUS_NULL_COMMAND;
      addr_q        <= '0;
      beats_q       <= '0;
      beat_q        <= '0;
      resp_idx_q    <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
      err_q         <= '0;
      tbl_vld_q     <= '0;
      for (int i = 0; i < NP; i++) begin
        tbl_cmd_q[i]  <= PZCOREBUS_NULL_COMMAND;
        tbl_addr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      beats_q       <= beats_d;
      beat_q        <= beat_d;
      resp_idx_q    <= resp_idx_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      tbl_vld_q     <= tbl_vld_d;
      tbl_cmd_q     <= tbl_cmd_d;
      tbl_addr_q    <= tbl_addr_d;
    end
  end
endmodule
